// File: rtl/altera_tse_gxb_rx_reset_ctrl_if.sv
// altera_tse_gxb_rx_reset_ctrl_if: transceiver status inputs and reset/status outputs of the rx reset controller
interface altera_tse_gxb_rx_reset_ctrl_if;
    logic       rx_pll_locked;
    logic       rx_freqlocked;
    logic       rx_sync;
    logic       rx_analogreset;
    logic       rx_digitalreset;
    logic       rx_ready;
    logic [7:0] resync_count;
    logic [2:0] ctrl_state;
    modport master (
        output rx_pll_locked, rx_freqlocked, rx_sync,
        input  rx_analogreset, rx_digitalreset, rx_ready, resync_count, ctrl_state
    );
    modport slave (
        input  rx_pll_locked, rx_freqlocked, rx_sync,
        output rx_analogreset, rx_digitalreset, rx_ready, resync_count, ctrl_state
    );
endinterface

// File: rtl/altera_tse_gxb_rx_reset_ctrl.sv
// altera_tse_gxb_rx_reset_ctrl: sequences GXB rx analog/digital resets from CDR lock and PCS sync status
module altera_tse_gxb_rx_reset_ctrl #(
    parameter int ANALOG_HOLD   = 32,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int SYNC_TIMEOUT  = 65535,
    parameter int LOSS_FILTER   = 16,
    parameter int DIG_HOLD      = 8
) (
    input  logic clk,
    input  logic reset,
    altera_tse_gxb_rx_reset_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        RST_ANALOG  = 3'd0,
        WAIT_LOCK   = 3'd1,
        WAIT_SETTLE = 3'd2,
        WAIT_SYNC   = 3'd3,
        READY       = 3'd4,
        RECOVER     = 3'd5
    } state_t;
    localparam logic [19:0] A_END = 20'(ANALOG_HOLD - 1);
    localparam logic [19:0] L_END = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] S_END = 20'(SETTLE_CYCLES - 1);
    localparam logic [19:0] Y_END = 20'(SYNC_TIMEOUT - 1);
    localparam logic [19:0] D_END = 20'(DIG_HOLD - 1);
    localparam logic [7:0]  F_END = 8'(LOSS_FILTER - 1);
    state_t      state, nxt;
    logic [19:0] dwell;
    logic [7:0]  loss;
    logic [7:0]  resync;
    logic        ana, dig, rdy;
    logic        lock, sync;
    assign lock = bus.rx_pll_locked & bus.rx_freqlocked;
    assign sync = bus.rx_sync;
    // Lock loss outranks every sync/timeout decision once the CDR has been accepted.
    always_comb begin
        nxt = state;
        case (state)
            RST_ANALOG:  nxt = (dwell == A_END) ? WAIT_LOCK : RST_ANALOG;
            WAIT_LOCK:   nxt = lock ? WAIT_SETTLE : (dwell == L_END) ? RST_ANALOG : WAIT_LOCK;
            WAIT_SETTLE: nxt = !lock ? WAIT_LOCK : (dwell == S_END) ? WAIT_SYNC : WAIT_SETTLE;
            WAIT_SYNC:   nxt = !lock ? RST_ANALOG : sync ? READY : (dwell == Y_END) ? RECOVER : WAIT_SYNC;
            READY:       nxt = !lock ? RST_ANALOG : (!sync && loss == F_END) ? RECOVER : READY;
            RECOVER:     nxt = !lock ? RST_ANALOG : (dwell == D_END) ? WAIT_SYNC : RECOVER;
            default:     nxt = RST_ANALOG;
        endcase
    end
    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RST_ANALOG;
            dwell  <= '0;
            loss   <= '0;
            resync <= '0;
            ana    <= 1'b1;
            dig    <= 1'b1;
            rdy    <= 1'b0;
        end else begin
            state  <= nxt;
            dwell  <= (nxt != state) ? '0 : (&dwell) ? dwell : dwell + 20'd1;
            loss   <= (state == READY && nxt == READY && !sync) ? ((&loss) ? loss : loss + 8'd1) : '0;
            resync <= (nxt == RECOVER && state != RECOVER && !(&resync)) ? resync + 8'd1 : resync;
            ana    <= nxt == RST_ANALOG;
            dig    <= nxt == RST_ANALOG || nxt == WAIT_LOCK || nxt == WAIT_SETTLE || nxt == RECOVER;
            rdy    <= nxt == READY;
        end
    end
    assign bus.rx_analogreset  = ana;
    assign bus.rx_digitalreset = dig;
    assign bus.rx_ready        = rdy;
    assign bus.resync_count    = resync;
    assign bus.ctrl_state      = state;
endmodule

// File: tb/tb_altera_tse_gxb_rx_reset_ctrl.sv
// tb_altera_tse_gxb_rx_reset_ctrl: directed sequences with hand-computed state/output expectations
module tb_altera_tse_gxb_rx_reset_ctrl;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    altera_tse_gxb_rx_reset_ctrl_if ifc ();
    altera_tse_gxb_rx_reset_ctrl #(
        .ANALOG_HOLD(4), .LOCK_TIMEOUT(50), .SETTLE_CYCLES(8),
        .SYNC_TIMEOUT(20), .LOSS_FILTER(4), .DIG_HOLD(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic outs(input string tag, input int st, input int a, input int d, input int r);
        chk({tag, " state"}, int'(ifc.ctrl_state), st);
        chk({tag, " analog"}, int'(ifc.rx_analogreset), a);
        chk({tag, " digital"}, int'(ifc.rx_digitalreset), d);
        chk({tag, " ready"}, int'(ifc.rx_ready), r);
    endtask
    initial begin
        reset = 1'b1;
        ifc.rx_pll_locked = 1'b1;
        ifc.rx_freqlocked = 1'b1;
        ifc.rx_sync = 1'b0;
        tick(1);
        reset = 1'b0;
        outs("reset", 0, 1, 1, 0);
        chk("reset resync", int'(ifc.resync_count), 0);
        // nominal bring-up
        tick(3);
        outs("analog hold 4th", 0, 1, 1, 0);
        tick(1);
        outs("wait lock", 1, 0, 1, 0);
        tick(1);
        outs("settle start", 2, 0, 1, 0);
        tick(7);
        outs("settle 8th", 2, 0, 1, 0);
        tick(1);
        outs("wait sync", 3, 0, 0, 0);
        tick(5);
        chk("still wait sync", int'(ifc.ctrl_state), 3);
        ifc.rx_sync = 1'b1;
        tick(1);
        outs("ready", 4, 0, 0, 1);
        // glitch filter
        ifc.rx_sync = 1'b0;
        tick(3);
        ifc.rx_sync = 1'b1;
        tick(1);
        outs("3-cycle dropout", 4, 0, 0, 1);
        ifc.rx_sync = 1'b0;
        tick(3);
        outs("dropout 3 of 4", 4, 0, 0, 1);
        tick(1);
        outs("recover", 5, 0, 1, 0);
        chk("resync after glitch", int'(ifc.resync_count), 1);
        ifc.rx_sync = 1'b1;
        tick(2);
        outs("recover 3rd", 5, 0, 1, 0);
        tick(1);
        outs("back to wait sync", 3, 0, 0, 0);
        tick(1);
        chk("ready again", int'(ifc.ctrl_state), 4);
        // lock loss coincides with 4th sync-low cycle
        ifc.rx_sync = 1'b0;
        tick(3);
        chk("pre lock loss", int'(ifc.ctrl_state), 4);
        ifc.rx_freqlocked = 1'b0;
        tick(1);
        outs("lock loss priority", 0, 1, 1, 0);
        chk("resync unchanged", int'(ifc.resync_count), 1);
        ifc.rx_freqlocked = 1'b1;
        ifc.rx_sync = 1'b1;
        tick(3);
        chk("analog after loss", int'(ifc.ctrl_state), 0);
        tick(1);
        chk("lock after loss", int'(ifc.ctrl_state), 1);
        tick(1);
        chk("settle again", int'(ifc.ctrl_state), 2);
        // settle abort, then lock timeout with dwell restarted
        tick(4);
        chk("settle cycle 5", int'(ifc.ctrl_state), 2);
        ifc.rx_pll_locked = 1'b0;
        tick(1);
        outs("settle abort", 1, 0, 1, 0);
        tick(49);
        outs("lock wait 50th", 1, 0, 1, 0);
        tick(1);
        outs("lock timeout", 0, 1, 1, 0);
        tick(3);
        chk("timeout hold", int'(ifc.ctrl_state), 0);
        tick(1);
        chk("timeout lock", int'(ifc.ctrl_state), 1);
        tick(49);
        chk("2nd timeout pending", int'(ifc.ctrl_state), 1);
        tick(1);
        outs("2nd timeout repulse", 0, 1, 1, 0);
        // sync timeout loop and saturation
        ifc.rx_pll_locked = 1'b1;
        ifc.rx_sync = 1'b0;
        tick(4);
        chk("st lock", int'(ifc.ctrl_state), 1);
        tick(9);
        chk("st wait sync", int'(ifc.ctrl_state), 3);
        tick(19);
        chk("st no timeout yet", int'(ifc.ctrl_state), 3);
        tick(1);
        outs("sync timeout", 5, 0, 1, 0);
        chk("resync 2", int'(ifc.resync_count), 2);
        tick(3);
        chk("st back wait sync", int'(ifc.ctrl_state), 3);
        for (int i = 0; i < 253; i++) tick(23);
        chk("resync reaches 255", int'(ifc.resync_count), 255);
        chk("loop phase", int'(ifc.ctrl_state), 3);
        for (int i = 0; i < 47; i++) tick(23);
        tick(20);
        chk("recover after sat", int'(ifc.ctrl_state), 5);
        chk("resync saturated", int'(ifc.resync_count), 255);
        // mid-run reset from READY
        ifc.rx_sync = 1'b1;
        tick(3);
        chk("wait sync pre ready", int'(ifc.ctrl_state), 3);
        tick(1);
        chk("ready pre reset", int'(ifc.ctrl_state), 4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        outs("mid reset", 0, 1, 1, 0);
        chk("mid reset resync", int'(ifc.resync_count), 0);
        tick(3);
        chk("mid reset hold", int'(ifc.ctrl_state), 0);
        tick(1);
        chk("mid reset release", int'(ifc.ctrl_state), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
